// File: rtl/stream_compare_checker.sv
// stream_compare_checker: waits for ref_i/dut_i to be stable for SETTLE cycles,
// then performs one compare per stable interval, counting compares and
// mismatches and capturing the first failing pair.
module stream_compare_checker #(
    parameter int unsigned N            = 8,
    parameter int unsigned SETTLE       = 4,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned STOP_ON_FAIL = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [N-1:0]     ref_i,
    input  logic [N-1:0]     dut_i,
    output logic             busy_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             error_o,
    output logic [CNT_W-1:0] cmp_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [N-1:0]     first_ref_o,
    output logic [N-1:0]     first_dut_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        FAIL = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE);

    state_t           state_q;
    logic [2*N-1:0]   prev_q;
    logic [7:0]       settle_q;
    logic             busy_q;
    logic             pass_q;
    logic             fail_q;
    logic             error_q;
    logic [CNT_W-1:0] cmp_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [N-1:0]     first_ref_q;
    logic [N-1:0]     first_dut_q;

    logic             change;
    logic             mismatch;
    logic [CNT_W-1:0] cmp_cnt_d;
    logic [CNT_W-1:0] err_cnt_d;

    // Change detection against last cycle's inputs; compare uses case
    // inequality so X/Z on either bus reads as a mismatch in simulation.
    always_comb begin
        change    = ({ref_i, dut_i} != prev_q);
        mismatch  = (ref_i !== dut_i);
        cmp_cnt_d = (cmp_cnt_q == '1) ? cmp_cnt_q : cmp_cnt_q + CNT_W'(1);
        err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_W'(1);
    end

    // Settle/compare state machine with registered status and pulse outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            settle_q    <= '0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            error_q     <= 1'b0;
            cmp_cnt_q   <= '0;
            err_cnt_q   <= '0;
            first_ref_q <= '0;
            first_dut_q <= '0;
        end else begin
            prev_q <= {ref_i, dut_i};
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            busy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en_i) begin
                        state_q  <= WAIT;
                        settle_q <= SETTLE_LD;
                        busy_q   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!en_i) begin
                        state_q <= IDLE;
                    end else if (change) begin
                        settle_q <= SETTLE_LD;
                        busy_q   <= 1'b1;
                    end else if (settle_q == 8'd1) begin
                        cmp_cnt_q <= cmp_cnt_d;
                        pass_q    <= !mismatch;
                        fail_q    <= mismatch;
                        if (mismatch) begin
                            err_cnt_q <= err_cnt_d;
                            error_q   <= 1'b1;
                            if (!error_q) begin
                                first_ref_q <= ref_i;
                                first_dut_q <= dut_i;
                            end
                        end
                        if (mismatch && (STOP_ON_FAIL != 0)) begin
                            state_q <= FAIL;
                        end else begin
                            state_q <= HOLD;
                        end
                    end else begin
                        settle_q <= settle_q - 8'd1;
                        busy_q   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!en_i) begin
                        state_q <= IDLE;
                    end else if (change) begin
                        state_q  <= WAIT;
                        settle_q <= SETTLE_LD;
                        busy_q   <= 1'b1;
                    end
                end
                FAIL: begin
                    state_q <= FAIL;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign error_o     = error_q;
    assign cmp_cnt_o   = cmp_cnt_q;
    assign err_cnt_o   = err_cnt_q;
    assign first_ref_o = first_ref_q;
    assign first_dut_o = first_dut_q;

endmodule

// File: tb/tb_stream_compare_checker.sv
// Bench for stream_compare_checker: a cycle-by-cycle vector table against the
// default instance, plus directed sequences for STOP_ON_FAIL=0, saturation
// with CNT_W=2 and SETTLE=1.
module tb_stream_compare_checker;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] ref_v;
    logic [7:0] dut_v;

    // Instance A: defaults (SETTLE=4, CNT_W=16, STOP_ON_FAIL=1)
    logic        a_busy, a_pass, a_fail, a_error;
    logic [15:0] a_cmp, a_ecnt;
    logic [7:0]  a_fref, a_fdut;
    // Instance B: STOP_ON_FAIL=0, CNT_W=2
    logic        b_busy, b_pass, b_fail, b_error;
    logic [1:0]  b_cmp, b_ecnt;
    logic [7:0]  b_fref, b_fdut;
    // Instance C: SETTLE=1, STOP_ON_FAIL=0
    logic        c_busy, c_pass, c_fail, c_error;
    logic [15:0] c_cmp, c_ecnt;
    logic [7:0]  c_fref, c_fdut;

    stream_compare_checker #(.N(8), .SETTLE(4), .CNT_W(16), .STOP_ON_FAIL(1)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .ref_i(ref_v), .dut_i(dut_v),
        .busy_o(a_busy), .pass_o(a_pass), .fail_o(a_fail), .error_o(a_error),
        .cmp_cnt_o(a_cmp), .err_cnt_o(a_ecnt), .first_ref_o(a_fref), .first_dut_o(a_fdut)
    );

    stream_compare_checker #(.N(8), .SETTLE(4), .CNT_W(2), .STOP_ON_FAIL(0)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .ref_i(ref_v), .dut_i(dut_v),
        .busy_o(b_busy), .pass_o(b_pass), .fail_o(b_fail), .error_o(b_error),
        .cmp_cnt_o(b_cmp), .err_cnt_o(b_ecnt), .first_ref_o(b_fref), .first_dut_o(b_fdut)
    );

    stream_compare_checker #(.N(8), .SETTLE(1), .CNT_W(16), .STOP_ON_FAIL(0)) u_c (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .ref_i(ref_v), .dut_i(dut_v),
        .busy_o(c_busy), .pass_o(c_pass), .fail_o(c_fail), .error_o(c_error),
        .cmp_cnt_o(c_cmp), .err_cnt_o(c_ecnt), .first_ref_o(c_fref), .first_dut_o(c_fdut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [7:0] rf;
        logic [7:0] du;
        logic       busy;
        logic       pass;
        logic       fail;
        logic       error;
        int         cmp;
        int         ecnt;
        logic [7:0] fref;
        logic [7:0] fdut;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic v(input logic r, input logic e, input logic [7:0] rf, input logic [7:0] du,
                     input logic b, input logic p, input logic f, input logic er,
                     input int c, input int ec, input logic [7:0] fr, input logic [7:0] fd);
        vec_t x;
        x.rst_n = r; x.en = e; x.rf = rf; x.du = du;
        x.busy = b; x.pass = p; x.fail = f; x.error = er;
        x.cmp = c; x.ecnt = ec; x.fref = fr; x.fdut = fd;
        tbl.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        ref_v = 8'h00;
        dut_v = 8'h00;

        // rst en ref dut | busy pass fail err cmp ecnt fref fdut
        v(0,0,8'hA5,8'hA5, 0,0,0,0, 0,0, 8'h00,8'h00);
        v(1,1,8'hA5,8'hA5, 1,0,0,0, 0,0, 8'h00,8'h00);  // IDLE->WAIT
        v(1,1,8'hA5,8'hA5, 1,0,0,0, 0,0, 8'h00,8'h00);
        v(1,1,8'hA5,8'hA5, 1,0,0,0, 0,0, 8'h00,8'h00);
        v(1,1,8'hA5,8'hA5, 1,0,0,0, 0,0, 8'h00,8'h00);
        v(1,1,8'hA5,8'hA5, 0,1,0,0, 1,0, 8'h00,8'h00);  // compare, 4 after enable
        v(1,1,8'hA5,8'hA5, 0,0,0,0, 1,0, 8'h00,8'h00);
        v(1,1,8'hA5,8'hA5, 0,0,0,0, 1,0, 8'h00,8'h00);
        v(1,1,8'h3C,8'h3D, 1,0,0,0, 1,0, 8'h00,8'h00);  // change in HOLD
        v(1,1,8'h3C,8'h3D, 1,0,0,0, 1,0, 8'h00,8'h00);
        v(1,1,8'h3C,8'h3D, 1,0,0,0, 1,0, 8'h00,8'h00);
        v(1,1,8'h3C,8'h3D, 1,0,0,0, 1,0, 8'h00,8'h00);
        v(1,1,8'h3C,8'h3D, 0,0,1,1, 2,1, 8'h3C,8'h3D);  // mismatch -> FAIL
        v(1,1,8'h00,8'h00, 0,0,0,1, 2,1, 8'h3C,8'h3D);
        v(1,0,8'h00,8'h00, 0,0,0,1, 2,1, 8'h3C,8'h3D);
        v(1,1,8'h77,8'h00, 0,0,0,1, 2,1, 8'h3C,8'h3D);
        v(1,1,8'h77,8'h00, 0,0,0,1, 2,1, 8'h3C,8'h3D);
        v(1,1,8'h77,8'h00, 0,0,0,1, 2,1, 8'h3C,8'h3D);
        v(0,1,8'h77,8'h00, 0,0,0,0, 0,0, 8'h00,8'h00);  // reset clears FAIL
        v(1,1,8'h11,8'h11, 1,0,0,0, 0,0, 8'h00,8'h00);
        v(1,1,8'h11,8'h11, 1,0,0,0, 0,0, 8'h00,8'h00);
        v(1,1,8'h11,8'h11, 1,0,0,0, 0,0, 8'h00,8'h00);  // settle_cnt==2
        v(0,1,8'h11,8'h11, 0,0,0,0, 0,0, 8'h00,8'h00);  // mid-WAIT reset
        v(1,1,8'h11,8'h11, 1,0,0,0, 0,0, 8'h00,8'h00);
        v(1,1,8'h11,8'h11, 1,0,0,0, 0,0, 8'h00,8'h00);
        v(1,1,8'h11,8'h11, 1,0,0,0, 0,0, 8'h00,8'h00);
        v(1,1,8'h11,8'h11, 1,0,0,0, 0,0, 8'h00,8'h00);
        v(1,1,8'h11,8'h11, 0,1,0,0, 1,0, 8'h00,8'h00);
        v(1,0,8'h11,8'h11, 0,0,0,0, 1,0, 8'h00,8'h00);  // HOLD->IDLE
        v(1,1,8'h11,8'h11, 1,0,0,0, 1,0, 8'h00,8'h00);
        v(1,1,8'h11,8'h11, 1,0,0,0, 1,0, 8'h00,8'h00);
        v(1,1,8'h11,8'h11, 1,0,0,0, 1,0, 8'h00,8'h00);
        v(1,1,8'h11,8'h11, 1,0,0,0, 1,0, 8'h00,8'h00);
        v(1,0,8'h11,8'h11, 0,0,0,0, 1,0, 8'h00,8'h00);  // en low suppresses due compare
        v(1,1,8'h11,8'h11, 1,0,0,0, 1,0, 8'h00,8'h00);
        v(1,1,8'h11,8'h11, 1,0,0,0, 1,0, 8'h00,8'h00);
        v(1,1,8'h11,8'h11, 1,0,0,0, 1,0, 8'h00,8'h00);
        v(1,1,8'h11,8'h11, 1,0,0,0, 1,0, 8'h00,8'h00);
        v(1,1,8'h12,8'h12, 1,0,0,0, 1,0, 8'h00,8'h00);  // change on compare edge
        v(1,1,8'h12,8'h12, 1,0,0,0, 1,0, 8'h00,8'h00);
        v(1,1,8'h12,8'h12, 1,0,0,0, 1,0, 8'h00,8'h00);
        v(1,1,8'h12,8'h12, 1,0,0,0, 1,0, 8'h00,8'h00);
        v(1,1,8'h12,8'h12, 0,1,0,0, 2,0, 8'h00,8'h00);
        v(1,1,8'h12,8'h12, 0,0,0,0, 2,0, 8'h00,8'h00);

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst_n;
            en    = tbl[i].en;
            ref_v = tbl[i].rf;
            dut_v = tbl[i].du;
            step();
            chk($sformatf("row%0d busy", i),  16'(a_busy),  16'(tbl[i].busy));
            chk($sformatf("row%0d pass", i),  16'(a_pass),  16'(tbl[i].pass));
            chk($sformatf("row%0d fail", i),  16'(a_fail),  16'(tbl[i].fail));
            chk($sformatf("row%0d error", i), 16'(a_error), 16'(tbl[i].error));
            chk($sformatf("row%0d cmp", i),   a_cmp,        16'(tbl[i].cmp));
            chk($sformatf("row%0d ecnt", i),  a_ecnt,       16'(tbl[i].ecnt));
            chk($sformatf("row%0d fref", i),  16'(a_fref),  16'(tbl[i].fref));
            chk($sformatf("row%0d fdut", i),  16'(a_fdut),  16'(tbl[i].fdut));
        end

        // Toggle dut every 3 cycles: settle never completes, busy stays high.
        do_reset();
        en = 1'b1; ref_v = 8'h20; dut_v = 8'h20;
        step();
        for (int c = 1; c <= 12; c++) begin
            if (c % 3 == 0) dut_v = dut_v ^ 8'h01;
            step();
            chk($sformatf("tog%0d busy", c), 16'(a_busy), 16'd1);
            chk($sformatf("tog%0d pulse", c), 16'({a_pass, a_fail}), 16'd0);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("tog_hold%0d pass", i), 16'(a_pass), 16'(i == 4));
            chk($sformatf("tog_hold%0d busy", i), 16'(a_busy), 16'(i < 4));
        end
        chk("tog cmp", a_cmp, 16'd1);

        // STOP_ON_FAIL=0: two mismatches, capture keeps the first pair.
        do_reset();
        en = 1'b1; ref_v = 8'h01; dut_v = 8'h02;
        repeat (5) step();
        chk("nsf1 fail", 16'(b_fail), 16'd1);
        chk("nsf1 ecnt", 16'(b_ecnt), 16'd1);
        chk("nsf1 error", 16'(b_error), 16'd1);
        ref_v = 8'h04; dut_v = 8'h08;
        repeat (5) step();
        chk("nsf2 fail", 16'(b_fail), 16'd1);
        chk("nsf2 ecnt", 16'(b_ecnt), 16'd2);
        chk("nsf2 cmp", 16'(b_cmp), 16'd2);
        chk("nsf2 fref", 16'(b_fref), 16'h01);
        chk("nsf2 fdut", 16'(b_fdut), 16'h02);
        chk("sof frozen cmp", a_cmp, 16'd1);
        chk("sof frozen ecnt", a_ecnt, 16'd1);
        chk("sof no pulse", 16'(a_fail), 16'd0);
        chk("sof fref", 16'(a_fref), 16'h01);

        // CNT_W=2 saturation over five matching intervals.
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ref_v = 8'h40 + 8'(k);
            dut_v = 8'h40 + 8'(k);
            repeat (5) step();
            chk($sformatf("sat%0d b_pass", k), 16'(b_pass), 16'd1);
            chk($sformatf("sat%0d b_cmp", k), 16'(b_cmp), 16'((k + 1 > 3) ? 3 : k + 1));
            chk($sformatf("sat%0d a_cmp", k), a_cmp, 16'(k + 1));
        end
        chk("sat b_ecnt", 16'(b_ecnt), 16'd0);

        // SETTLE=1: compare on the first stable edge; a change there cancels it.
        do_reset();
        en = 1'b1; ref_v = 8'h55; dut_v = 8'h55;
        step();
        chk("s1 e0 busy", 16'(c_busy), 16'd1);
        chk("s1 e0 pass", 16'(c_pass), 16'd0);
        step();
        chk("s1 pass", 16'(c_pass), 16'd1);
        chk("s1 busy", 16'(c_busy), 16'd0);
        chk("s1 cmp", c_cmp, 16'd1);
        ref_v = 8'h56; dut_v = 8'h56;
        step();
        chk("s1 rewait busy", 16'(c_busy), 16'd1);
        ref_v = 8'h57; dut_v = 8'h57;
        step();
        chk("s1 cancel pass", 16'(c_pass), 16'd0);
        chk("s1 cancel busy", 16'(c_busy), 16'd1);
        step();
        chk("s1 pass2", 16'(c_pass), 16'd1);
        chk("s1 cmp2", c_cmp, 16'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
